imem_boot_loader: RTL
=====================

# imem_boot_loader

Boot-time loader and run controller for the core's byte-addressed instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and drives the memory's write port (`loadData`, `loadAddr`, `wrEn`) at sequential word addresses. It holds the core out of execution while loading and releases it with a run enable once the final word is written. It sits between the external program source (debug/UART bridge) and the instruction memory plus core reset/run gating.

## Interface
- `MEM_BYTES`, 4096, instruction memory size in bytes; a multiple of 4.
- `BASE_ADDR`, 0, byte address of the first loaded word; 4-byte aligned.
- `LEN_W`, $clog2(MEM_BYTES/4)+1, width of the word-count fields.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  load request; sampled only in IDLE, RUN and ERR.
- `len_i`  in  LEN_W  number of words to load; sampled with `start_i`.
- `word_i`  in  32  instruction word.
- `word_valid_i`  in  1  `word_i` valid.
- `word_ready_o`  out  1  loader can accept `word_i`.
- `loadData_o`  out  32  memory write data.
- `loadAddr_o`  out  64  memory write byte address; zero-extended.
- `wrEn_o`  out  1  memory write strobe, one cycle per word.
- `core_run_o`  out  1  core enable; 0 holds the core in reset/stall.
- `done_o`  out  1  one-cycle pulse when a load completes.
- `error_o`  out  1  length-overflow error; sticky.
- `words_loaded_o`  out  LEN_W  count of words written in the current or last load.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, ERR. Encoding is free.
- Reset values: state IDLE, `word_ready_o`=0, `wrEn_o`=0, `loadData_o`=0, `loadAddr_o`=0, `core_run_o`=0, `done_o`=0, `error_o`=0, `words_loaded_o`=0.
- Overflow check on `start_i`: error if BASE_ADDR + 4*`len_i` > MEM_BYTES. Compute at ≥ 64-bit width so there is no wrap.
- IDLE/RUN/ERR with `start_i`=1:
  - Overflow: go to ERR, set `error_o`=1, `core_run_o`=0, no writes.
  - `len_i`=0: go to RUN with a `done_o` pulse and no writes. Clear `error_o`.
  - Otherwise: go to LOAD. Internal address=BASE_ADDR, count=0, `words_loaded_o`=0, `core_run_o`=0, clear `error_o`.
- LOAD:
  - `word_ready_o`=1.
  - On `word_valid_i`&`word_ready_o`: register `word_i` and the current address onto `loadData_o`/`loadAddr_o` with `wrEn_o`=1 for the next cycle. Then address+=4, count+=1, `words_loaded_o`=count+1.
  - If that was word `len_i`, go to FLUSH.
  - `start_i` is ignored in LOAD.
- FLUSH: `word_ready_o`=0. The final write is on the port this cycle. Go to RUN next cycle.
- RUN: `core_run_o`=1. `done_o`=1 for the first RUN cycle only. `start_i` reloads as above, and `core_run_o` drops in the same edge.
- ERR: `core_run_o`=0. Stays in ERR until a valid `start_i` arrives.
- `wrEn_o` is 0 in every cycle without a write. `loadData_o`/`loadAddr_o` hold their last written values.

## Timing
- Write latency: handshake in cycle N → `wrEn_o`=1 with that word/address in cycle N+1.
- Back-to-back accepts give back-to-back writes at throughput 1 word/clock. Stalls on `word_valid_i`=0 produce gaps with no writes.
- Last handshake in cycle N: FLUSH and last write in N+1; RUN, `core_run_o`=1, and `done_o` pulse in N+2.
- `start_i` in cycle N: state change visible in cycle N+1. `word_ready_o`=1 from N+1 on a valid load.
- Reset asserted mid-load: all outputs return to reset values immediately. Memory contents are undefined. The core stays held until a new load completes.
- Address never exceeds BASE_ADDR + 4*(`len_i`−1) ≤ MEM_BYTES−4.

## Test plan
- Reset, then `start_i`, `len_i`=4, feed 0x00000013, 0x00100093, 0x00200113, 0x002081B3 with valid held high → `wrEn_o` high for 4 consecutive cycles at addresses 0,4,8,12 with matching data. `done_o` pulses 2 cycles after the 4th handshake, then `core_run_o`=1 and `words_loaded_o`=4.
- Same load with `word_valid_i` toggled 1,0,0,1,1,0,1,1 → exactly 4 writes, no write in gap cycles, addresses still 0,4,8,12.
- `len_i`=1025 with MEM_BYTES=4096 → ERR, `error_o`=1, zero writes, `core_run_o`=0. A following `start_i`, `len_i`=1024 → `error_o` clears, 1024 writes, last address 4092.
- `len_i`=0 → next cycle in RUN, `done_o` pulse, no write, `core_run_o`=1.
- Reset asserted after 2 of 4 words → all outputs at reset values asynchronously. A subsequent load of 2 words completes normally from address 0.
- In RUN, `start_i`, `len_i`=2 → `core_run_o` drops next cycle, 2 writes from BASE_ADDR, `done_o` pulses and `core_run_o` returns to 1. `start_i` pulsed during LOAD is ignored.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if
//   Groups the instruction-word stream handshake and the instruction memory
//   write port of imem_boot_loader.
//   master : loader side (consumes the word stream, drives the memory port)
//   slave  : environment side (program source + instruction memory)
//   word_i/word_valid_i/word_ready_o : 32-bit word stream, valid/ready
//   loadData_o/loadAddr_o/wrEn_o     : memory write data, byte address, strobe
interface imem_boot_loader_if;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [31:0] loadData_o;
  logic [63:0] loadAddr_o;
  logic        wrEn_o;

  modport master (
    input  word_i, word_valid_i,
    output word_ready_o, loadData_o, loadAddr_o, wrEn_o
  );

  modport slave (
    output word_i, word_valid_i,
    input  word_ready_o, loadData_o, loadAddr_o, wrEn_o
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader and run controller for the byte-addressed instruction
//   memory. Accepts len_i words over the bus word stream, writes them to
//   sequential word addresses starting at BASE_ADDR, holds the core while
//   loading and releases it (core_run_o) once the last word is written.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   start_i, len_i    : load request and word count (sampled in IDLE/RUN/ERR)
//   bus               : word stream + memory write port (master modport)
//   core_run_o        : core enable
//   done_o            : one-cycle pulse on load completion
//   error_o           : sticky length-overflow flag
//   words_loaded_o    : words written in the current/last load
module imem_boot_loader #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned LEN_W     = $clog2(MEM_BYTES/4) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  imem_boot_loader_if.master   bus,
  output logic                 core_run_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [LEN_W-1:0]     words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_loaded_q, words_loaded_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [63:0]       load_addr_q, load_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // End-of-load byte address computed two bits wider than the address so the
  // overflow test can never wrap.
  logic [65:0]       end_byte;
  logic              overflow;
  logic [LEN_W-1:0]  words_inc;

  assign end_byte  = 66'(BASE_ADDR) + (66'(len_i) << 2);
  assign overflow  = end_byte > 66'(MEM_BYTES);
  assign words_inc = words_loaded_q + LEN_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      words_loaded_q <= '0;
      load_data_q    <= '0;
      load_addr_q    <= '0;
      wr_en_q        <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      words_loaded_q <= words_loaded_d;
      load_data_q    <= load_data_d;
      load_addr_q    <= load_addr_d;
      wr_en_q        <= wr_en_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    words_loaded_d = words_loaded_q;
    load_data_d    = load_data_q;
    load_addr_d    = load_addr_q;
    wr_en_d        = 1'b0;
    done_d         = 1'b0;
    error_d        = error_q;

    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start_i) begin
          if (overflow) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_i == '0) begin
            state_d = S_RUN;
            done_d  = 1'b1;
            error_d = 1'b0;
          end else begin
            state_d        = S_LOAD;
            addr_d         = 64'(BASE_ADDR);
            len_d          = len_i;
            words_loaded_d = '0;
            error_d        = 1'b0;
          end
        end
      end
      S_LOAD: begin
        // word_ready_o is high throughout LOAD, so valid alone is a handshake.
        if (bus.word_valid_i) begin
          load_data_d    = bus.word_i;
          load_addr_d    = addr_q;
          wr_en_d        = 1'b1;
          addr_d         = addr_q + 64'd4;
          words_loaded_d = words_inc;
          if (words_inc == len_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.word_ready_o = (state_q == S_LOAD);
  assign bus.loadData_o   = load_data_q;
  assign bus.loadAddr_o   = load_addr_q;
  assign bus.wrEn_o       = wr_en_q;
  assign core_run_o       = (state_q == S_RUN);
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign words_loaded_o   = words_loaded_q;

endmodule
